// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU byte writes feed a small FIFO that
// drains through a registered shifter onto uart_txd; status is read combinationally.
module uart_tx_mmio #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_txd,
    output logic        tx_idle
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             txd_q;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             overflow;

    logic fifo_full;
    logic fifo_empty;
    logic push_req;
    logic push;
    logic pop;
    logic status_wr;
    logic baud_done;
    logic [31:0] status;
    logic unused_bits;

    assign fifo_full  = (fifo_cnt == DEPTH);
    assign fifo_empty = (fifo_cnt == '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    assign push_req  = ~cs_n & we & (addr[3:2] == 2'd0) & be[0];
    assign status_wr = ~cs_n & we & (addr[3:2] == 2'd1) & be[0];

    // The shifter takes a byte when idle, or straight out of a finishing stop bit.
    assign pop  = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & baud_done));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push = push_req & (~fifo_full | pop);

    assign unused_bits = ^{addr[1:0], be[3:1], wdata[31:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && !push)
                overflow <= 1'b1;
            else if (status_wr && wdata[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (pop)
            shift_reg <= fifo_mem[rd_ptr];
        else if ((state == S_DATA) && baud_done)
            shift_reg <= {1'b0, shift_reg[7:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            txd_q    <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd_q    <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= S_START;
                        txd_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        txd_q    <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= S_START;
                            txd_q <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign tx_idle  = fifo_empty & (state == S_IDLE);

    always_comb begin
        status      = '0;
        status[0]   = (state != S_IDLE);
        status[1]   = fifo_full;
        status[2]   = fifo_empty;
        status[3]   = overflow;
        status[7:4] = 4'(fifo_cnt);
    end

    always_comb begin
        rdata = '0;
        if (!cs_n && (addr[3:2] == 2'd1))
            rdata = status;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at 8 clocks per bit: register decode table,
// single and back-to-back frames, FIFO overflow, and reset mid-frame.
module tb_uart_tx_mmio;

    localparam int TB_CLK  = 8;
    localparam int TB_BAUD = 1;
    localparam int CPB     = TB_CLK / TB_BAUD;
    localparam int FRAME   = 10 * CPB;

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_txd;
    logic        tx_idle;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [8];

    typedef struct {
        logic        cs_n;
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rd_cs_n;
        logic [3:0]  rd_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    uart_tx_mmio #(
        .CLOCK_FREQ(TB_CLK),
        .BAUD_RATE (TB_BAUD),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (cs_n),
        .we      (we),
        .addr    (addr),
        .be      (be),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_txd(uart_txd),
        .tx_idle (tx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_op(input logic c, input logic w, input logic [3:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        cs_n  = c;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        @(posedge clk);
        #1;
        cs_n  = 1'b1;
        we    = 1'b0;
        addr  = 4'h0;
        be    = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        bus_op(1'b0, 1'b1, a, b, d);
    endtask

    task automatic read_status(output logic [31:0] v);
        cs_n = 1'b0;
        we   = 1'b0;
        addr = 4'h4;
        #1;
        v    = rdata;
        cs_n = 1'b1;
        addr = 4'h0;
    endtask

    // Line level of bit k (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0)
            return 1'b0;
        else if (k == 9)
            return 1'b1;
        else
            return b[k-1];
    endfunction

    // p counts cycles since the first start bit went low; exp_q holds the n bytes expected.
    task automatic watch(input int p0, input int n);
        logic [31:0] st;
        for (int p = p0; p <= FRAME * n; p++) begin
            if (p % CPB == CPB / 2)
                chk($sformatf("frame%0d_bit%0d", p / FRAME, (p % FRAME) / CPB), 32'(uart_txd),
                    32'(fbit(exp_q[p / FRAME], (p % FRAME) / CPB)));
            if ((p % FRAME == FRAME - 1) && (p < FRAME * n - 1))
                chk($sformatf("stop_end%0d", p / FRAME), 32'(uart_txd), 32'd1);
            if ((p > 0) && (p % FRAME == 0) && (p < FRAME * n)) begin
                chk($sformatf("next_start%0d", p / FRAME), 32'(uart_txd), 32'd0);
                read_status(st);
                chk($sformatf("count_at_frame%0d", p / FRAME), 32'(st[7:4]), 32'(n - 1 - p / FRAME));
            end
            if (p == FRAME * n - 1)
                chk("tx_idle_before_end", 32'(tx_idle), 32'd0);
            if (p == FRAME * n) begin
                chk("tx_idle_at_end", 32'(tx_idle), 32'd1);
                chk("txd_at_end", 32'(uart_txd), 32'd1);
            end
            if (p < FRAME * n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [31:0] st;
        int lows;

        vecs[0] = '{1'b0, 1'b1, 4'h0, 4'b0010, 32'h0000_005A, 1'b0, 4'h4, 32'h4};
        vecs[1] = '{1'b1, 1'b1, 4'h0, 4'b1111, 32'h0000_005A, 1'b1, 4'h4, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 4'h8, 4'b1111, 32'h0000_005A, 1'b0, 4'h8, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 4'hC, 4'b1111, 32'h0000_005A, 1'b0, 4'hC, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 4'h4, 4'b1111, 32'hFFFF_FFFF, 1'b0, 4'h4, 32'h4};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 4'b1111, 32'h0000_005A, 1'b0, 4'h0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 4'h1, 4'b1110, 32'h0000_00C3, 1'b0, 4'h5, 32'h4};

        reset = 1'b1;
        cs_n  = 1'b1;
        we    = 1'b0;
        addr  = 4'h0;
        be    = 4'h0;
        wdata = 32'h0;
        cycles(3);
        reset = 1'b0;

        // Reset state
        read_status(st);
        chk("reset_status", st, 32'h4);
        chk("reset_txd", 32'(uart_txd), 32'd1);
        chk("reset_tx_idle", 32'(tx_idle), 32'd1);
        cs_n = 1'b1;
        addr = 4'h4;
        #1;
        chk("rdata_deselected", rdata, 32'h0);
        addr = 4'h0;

        // Ignored writes and read decode
        for (int i = 0; i < 7; i++) begin
            bus_op(vecs[i].cs_n, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            cycles(2);
            cs_n = vecs[i].rd_cs_n;
            we   = 1'b0;
            addr = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            cs_n = 1'b1;
            addr = 4'h0;
            read_status(st);
            chk($sformatf("vec%0d_status", i), st, 32'h4);
            chk($sformatf("vec%0d_txd", i), 32'(uart_txd), 32'd1);
            chk($sformatf("vec%0d_tx_idle", i), 32'(tx_idle), 32'd1);
        end

        // Single frame 0xA5
        bus_write(4'h0, 4'b0001, 32'h0000_00A5);
        chk("a5_txd_write_edge", 32'(uart_txd), 32'd1);
        read_status(st);
        chk("a5_status_write_edge", st, 32'h10);
        chk("a5_tx_idle_write_edge", 32'(tx_idle), 32'd0);
        cycles(1);
        chk("a5_txd_fall", 32'(uart_txd), 32'd0);
        read_status(st);
        chk("a5_status_pop", st, 32'h5);
        exp_q[0] = 8'hA5;
        watch(0, 1);

        // Back-to-back frames 0x55, 0x0F
        bus_write(4'h0, 4'b0001, 32'h0000_0055);
        bus_write(4'h0, 4'b0001, 32'h0000_000F);
        chk("b2b_txd_fall", 32'(uart_txd), 32'd0);
        read_status(st);
        chk("b2b_status_first", st, 32'h11);
        exp_q[0] = 8'h55;
        exp_q[1] = 8'h0F;
        watch(0, 2);

        // Overflow: one byte in the shifter, four queued, fifth dropped
        bus_write(4'h0, 4'b0001, 32'h0000_003C);
        bus_write(4'h0, 4'b0001, 32'h0000_0081);
        bus_write(4'h0, 4'b0001, 32'h0000_007E);
        bus_write(4'h0, 4'b0001, 32'h0000_00C3);
        bus_write(4'h0, 4'b0001, 32'h0000_0018);
        bus_write(4'h0, 4'b0001, 32'h0000_00E7);
        read_status(st);
        chk("ovf_status_full", st, 32'h4B);
        bus_write(4'h4, 4'b0001, 32'h0000_0008);
        read_status(st);
        chk("ovf_status_cleared", st, 32'h43);
        exp_q[0] = 8'h3C;
        exp_q[1] = 8'h81;
        exp_q[2] = 8'h7E;
        exp_q[3] = 8'hC3;
        exp_q[4] = 8'h18;
        watch(5, 5);

        // Reset during data bit 3 with two bytes queued and a write on the reset edge
        bus_write(4'h0, 4'b0001, 32'h0000_0096);
        bus_write(4'h0, 4'b0001, 32'h0000_0011);
        bus_write(4'h0, 4'b0001, 32'h0000_0022);
        read_status(st);
        chk("rst_status_queued", st, 32'h21);
        cycles(35);
        chk("rst_txd_bit3", 32'(uart_txd), 32'd0);
        reset = 1'b1;
        cs_n  = 1'b0;
        we    = 1'b1;
        addr  = 4'h0;
        be    = 4'b0001;
        wdata = 32'h0000_0033;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cs_n  = 1'b1;
        we    = 1'b0;
        be    = 4'h0;
        wdata = 32'h0;
        chk("rst_txd_edge", 32'(uart_txd), 32'd1);
        chk("rst_tx_idle_edge", 32'(tx_idle), 32'd1);
        read_status(st);
        chk("rst_status_after", st, 32'h4);
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (uart_txd !== 1'b1 || tx_idle !== 1'b1)
                lows++;
        end
        chk("rst_no_more_frames", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
